// File: rtl/gerador_comparacao.sv
// Password comparison producer: stores the lock password and, on request, streams one
// match bit per digit to the downstream verifier, tracking failed attempts and lockout.
module gerador_comparacao #(
  parameter int                          N_DIGITOS      = 4,
  parameter int                          DW             = 4,
  parameter logic [N_DIGITOS*DW-1:0]     SENHA_PADRAO   = 16'h1234,
  parameter int                          MAX_TENTATIVAS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iniciar,
  input  logic                    gravar,
  input  logic [N_DIGITOS*DW-1:0] senha_entrada,
  output logic                    comparacao,
  output logic                    ocupado,
  output logic                    fim,
  output logic                    acerto,
  output logic                    bloqueado,
  output logic [2:0]              erros
);

  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam logic [IW-1:0] ULTIMO_INDICE = IW'(N_DIGITOS - 1);
  localparam logic [3:0]    LIMITE_ERROS  = 4'(MAX_TENTATIVAS);

  typedef enum logic [1:0] {
    OCIOSO,
    COMPARA,
    FIM
  } estado_t;

  estado_t                 estado_q;
  logic [N_DIGITOS*DW-1:0] senha_q;
  logic [N_DIGITOS*DW-1:0] codigo_q;
  logic [IW-1:0]           indice_q;
  logic                    ok_acc_q;
  logic                    acerto_q;
  logic [2:0]              erros_q;
  logic                    bloqueado_q;

  logic                    comparacao_d;
  logic [3:0]              erros_mais_um_d;
  logic [2:0]              erros_sat_d;
  logic                    atinge_limite_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    comparacao_d = 1'b0;
    if (estado_q == COMPARA) begin
      for (int i = 0; i < N_DIGITOS; i++) begin
        if (indice_q == IW'(i)) begin
          comparacao_d = (codigo_q[(N_DIGITOS-1-i)*DW +: DW] ==
                          senha_q[(N_DIGITOS-1-i)*DW +: DW]);
        end
      end
    end
  end

  // Failure bookkeeping is evaluated one bit wider so the lockout threshold sees the
  // unsaturated count.
  always_comb begin
    erros_mais_um_d = {1'b0, erros_q} + 4'd1;
    erros_sat_d     = (erros_q == 3'd7) ? 3'd7 : erros_mais_um_d[2:0];
    atinge_limite_d = (erros_mais_um_d >= LIMITE_ERROS);
  end

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q    <= OCIOSO;
      senha_q     <= SENHA_PADRAO;
      codigo_q    <= '0;
      indice_q    <= '0;
      ok_acc_q    <= 1'b0;
      acerto_q    <= 1'b0;
      erros_q     <= 3'd0;
      bloqueado_q <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (!bloqueado_q) begin
            if (iniciar) begin
              codigo_q <= senha_entrada;
              indice_q <= '0;
              ok_acc_q <= 1'b1;
              estado_q <= COMPARA;
            end else if (gravar) begin
              senha_q <= senha_entrada;
            end
          end
        end
        COMPARA: begin
          ok_acc_q <= ok_acc_q & comparacao_d;
          indice_q <= indice_q + 1'b1;
          if (indice_q == ULTIMO_INDICE) begin
            acerto_q <= ok_acc_q & comparacao_d;
            estado_q <= FIM;
          end
        end
        FIM: begin
          if (acerto_q) begin
            erros_q <= 3'd0;
          end else begin
            erros_q <= erros_sat_d;
            if (atinge_limite_d) begin
              bloqueado_q <= 1'b1;
            end
          end
          estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign comparacao = comparacao_d;
  assign ocupado    = (estado_q != OCIOSO);
  assign fim        = (estado_q == FIM);
  assign acerto     = acerto_q;
  assign bloqueado  = bloqueado_q;
  assign erros      = erros_q;

endmodule

// File: tb/tb_gerador_comparacao.sv
// Self-checking bench for gerador_comparacao: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_gerador_comparacao;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MAXT = 3;
  localparam logic [15:0] PADRAO = 16'h1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iniciar = 1'b0;
  logic        gravar = 1'b0;
  logic [15:0] senha_entrada = 16'h0000;
  logic        comparacao, ocupado, fim, acerto, bloqueado;
  logic [2:0]  erros;

  int n_checks = 0;
  int n_fail   = 0;

  gerador_comparacao #(
    .N_DIGITOS(N), .DW(DW), .SENHA_PADRAO(PADRAO), .MAX_TENTATIVAS(MAXT)
  ) dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .gravar(gravar),
    .senha_entrada(senha_entrada), .comparacao(comparacao), .ocupado(ocupado),
    .fim(fim), .acerto(acerto), .bloqueado(bloqueado), .erros(erros)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted attempt becomes a list of expected busy cycles.
  typedef struct {
    logic comp;
    logic fim;
    logic ok;
  } ciclo_t;

  ciclo_t      fila[$];
  logic [15:0] senha_m = PADRAO;
  logic [2:0]  erros_m = 3'd0;
  logic        bloq_m = 1'b0;
  logic        acerto_m = 1'b0;

  function automatic logic [3:0] digito(input logic [15:0] v, input int i);
    return v[(N-1-i)*DW +: DW];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fila.delete();
      senha_m  = PADRAO;
      erros_m  = 3'd0;
      bloq_m   = 1'b0;
      acerto_m = 1'b0;
    end else if (fila.size() != 0) begin
      ciclo_t c;
      c = fila.pop_front();
      if (c.fim) begin
        if (c.ok) erros_m = 3'd0;
        else begin
          if (erros_m != 3'd7) erros_m = erros_m + 3'd1;
          if (int'(erros_m) >= MAXT) bloq_m = 1'b1;
        end
      end
    end else if (!bloq_m && iniciar) begin
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < N; i++) begin
        logic m;
        m = (digito(senha_entrada, i) == digito(senha_m, i));
        ok = ok & m;
        fila.push_back('{comp: m, fim: 1'b0, ok: 1'b0});
      end
      fila.push_back('{comp: 1'b0, fim: 1'b1, ok: ok});
    end else if (!bloq_m && gravar) begin
      senha_m = senha_entrada;
    end
  end

  always @(negedge clk) begin
    if (fila.size() != 0) begin
      check("cmp_comparacao", comparacao, fila[0].comp);
      check("cmp_ocupado", ocupado, 1'b1);
      check("cmp_fim", fim, fila[0].fim);
      if (fila[0].fim) begin
        check("cmp_acerto_fim", acerto, fila[0].ok);
        acerto_m = fila[0].ok;
      end else begin
        check("cmp_acerto_hold", acerto, acerto_m);
      end
    end else begin
      check("cmp_comparacao_idle", comparacao, 1'b0);
      check("cmp_ocupado_idle", ocupado, 1'b0);
      check("cmp_fim_idle", fim, 1'b0);
      check("cmp_acerto_idle", acerto, acerto_m);
    end
    check("cmp_erros", erros, erros_m);
    check("cmp_bloqueado", bloqueado, bloq_m);
  end

  // Runs one attempt; senha_entrada is scrambled right after acceptance to show it is latched.
  task automatic run_code(input logic [15:0] code, input logic with_gravar,
                          input logic [3:0] exp_bits, input logic exp_ok,
                          input logic [2:0] exp_erros, input logic exp_bloq);
    logic [3:0] got;
    @(negedge clk); #1;
    senha_entrada = code;
    iniciar = 1'b1;
    gravar = with_gravar;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      got[N-1-i] = comparacao;
      if (i == 0) begin
        #1;
        iniciar = 1'b0;
        gravar = 1'b0;
        senha_entrada = ~code;
      end
    end
    check("seq_bits", got, exp_bits);
    @(negedge clk);
    check("seq_fim", fim, 1'b1);
    check("seq_acerto", acerto, exp_ok);
    @(negedge clk);
    check("seq_fim_drop", fim, 1'b0);
    check("seq_erros", erros, exp_erros);
    check("seq_bloqueado", bloqueado, exp_bloq);
  endtask

  task automatic do_gravar(input logic [15:0] code);
    @(negedge clk); #1;
    senha_entrada = code;
    gravar = 1'b1;
    @(negedge clk); #1;
    gravar = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check("reset_comparacao", comparacao, 1'b0);
    check("reset_ocupado", ocupado, 1'b0);
    check("reset_fim", fim, 1'b0);
    check("reset_acerto", acerto, 1'b0);
    check("reset_erros", erros, 3'd0);
    check("reset_bloqueado", bloqueado, 1'b0);
    @(negedge clk); #1 rst = 1'b1;

    run_code(16'h1234, 1'b0, 4'b1111, 1'b1, 3'd0, 1'b0);
    run_code(16'h1294, 1'b0, 4'b1101, 1'b0, 3'd1, 1'b0);

    do_gravar(16'h9876);
    run_code(16'h9876, 1'b0, 4'b1111, 1'b1, 3'd0, 1'b0);
    run_code(16'h1234, 1'b0, 4'b0000, 1'b0, 3'd1, 1'b0);
    do_gravar(16'h1234);

    run_code(16'h5555, 1'b1, 4'b0000, 1'b0, 3'd2, 1'b0);
    run_code(16'h1234, 1'b0, 4'b1111, 1'b1, 3'd0, 1'b0);

    run_code(16'h0000, 1'b0, 4'b0000, 1'b0, 3'd1, 1'b0);
    run_code(16'h0000, 1'b0, 4'b0000, 1'b0, 3'd2, 1'b0);
    run_code(16'h0000, 1'b0, 4'b0000, 1'b0, 3'd3, 1'b1);

    @(negedge clk); #1;
    senha_entrada = 16'h1234;
    iniciar = 1'b1;
    @(negedge clk);
    check("lock_ocupado", ocupado, 1'b0);
    #1 iniciar = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("lock_ocupado_hold", ocupado, 1'b0);
      check("lock_comparacao", comparacao, 1'b0);
    end

    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
    do_gravar(16'h9876);
    @(negedge clk); #1;
    senha_entrada = 16'h9876;
    iniciar = 1'b1;
    @(negedge clk); #1 iniciar = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_ocupado_before", ocupado, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_comparacao", comparacao, 1'b0);
    check("mid_ocupado", ocupado, 1'b0);
    check("mid_fim", fim, 1'b0);
    check("mid_acerto", acerto, 1'b0);
    check("mid_erros", erros, 3'd0);
    check("mid_bloqueado", bloqueado, 1'b0);
    @(negedge clk); #1 rst = 1'b1;
    run_code(16'h1234, 1'b0, 4'b1111, 1'b1, 3'd0, 1'b0);
    run_code(16'h9876, 1'b0, 4'b0000, 1'b0, 3'd1, 1'b0);

    for (int k = 0; k < 600; k++) begin
      logic [15:0] code;
      @(negedge clk); #1;
      case ($urandom_range(0, 2))
        0: code = senha_m;
        1: code = 16'($urandom);
        default: code = senha_m ^ (16'hF << (4 * $urandom_range(0, 3)));
      endcase
      senha_entrada = code;
      iniciar = ($urandom_range(0, 3) == 0);
      gravar  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 119) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk); #1 rst = 1'b1;
      end
    end
    @(negedge clk); #1;
    iniciar = 1'b0;
    gravar = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
